// File: rtl/immediate_generate_pipe_if.sv
// Handshake bundle between decoder, immediate generator and ID/EX register.
// The slave modport is the generator's view of the bundle; the master modport is the driver's view.
interface immediate_generate_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [24:0]      IN_INSTR;
    logic [3:0]       IN_IMM_SEL;
    logic [TAG_W-1:0] IN_TAG;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [XLEN-1:0]  OUT_IMM;
    logic [TAG_W-1:0] OUT_TAG;
    logic             OUT_ILLEGAL;

    modport master (
        output IN_VALID, IN_INSTR, IN_IMM_SEL, IN_TAG, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_IMM, OUT_TAG, OUT_ILLEGAL
    );

    modport slave (
        input  IN_VALID, IN_INSTR, IN_IMM_SEL, IN_TAG, OUT_READY,
        output IN_READY, OUT_VALID, OUT_IMM, OUT_TAG, OUT_ILLEGAL
    );
endinterface

// File: rtl/immediate_generate_pipe.sv
// Registered immediate generator with a 2-entry skid buffer (output reg + skid reg).
// Absorbs one cycle of downstream stall; FLUSH drops all buffered entries.
module immediate_generate_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input logic                     CLK,
    input logic                     RESET,
    input logic                     FLUSH,
    immediate_generate_pipe_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:7]      inst;
    logic             s;
    logic [31:0]      imm32;
    logic             in_ill;
    logic [XLEN-1:0]  in_imm;
    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             pop;
    logic             load_in;
    logic             load_skid;
    logic             load_from_skid;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_ill;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_ill;

    assign inst = bus.IN_INSTR;
    assign s    = inst[31];

    always_comb begin
        imm32  = '0;
        in_ill = 1'b0;
        case (bus.IN_IMM_SEL)
            4'b0000: imm32 = {inst[31:12], 12'b0};
            4'b0001: imm32 = {{11{s}}, s, inst[19:12], inst[20], inst[30:21], 1'b0};
            4'b0010: imm32 = {{20{s}}, inst[31:25], inst[11:7]};
            4'b0011: imm32 = {{19{s}}, s, inst[7], inst[30:25], inst[11:8], 1'b0};
            4'b0100: imm32 = {{20{s}}, inst[31:20]};
            4'b0101: imm32 = {27'b0, inst[24:20]};
            4'b0110: imm32 = {20'b0, inst[31:20]};
            4'b0111: imm32 = {27'b0, inst[19:15]};
            4'b1000: begin
                if (XLEN == 64) imm32 = {26'b0, inst[25:20]};
                else            in_ill = 1'b1;
            end
            default: in_ill = 1'b1;
        endcase
    end

    // Zero-extended formats always leave bit 31 clear, so one sign extension covers every format.
    assign in_imm = XLEN'($signed(imm32));

    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign accept    = bus.IN_VALID & in_ready;
    assign pop       = out_valid & bus.OUT_READY;

    always_ff @(posedge CLK) begin
        if (RESET) state <= EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_in        = 1'b0;
        load_skid      = 1'b0;
        load_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_in   = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_in = 1'b1;
                end else if (accept) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt      = ONE;
                    load_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (FLUSH) begin
            state_nxt      = EMPTY;
            load_in        = 1'b0;
            load_skid      = 1'b0;
            load_from_skid = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_imm  <= '0;
            out_tag  <= '0;
            out_ill  <= 1'b0;
            skid_imm <= '0;
            skid_tag <= '0;
            skid_ill <= 1'b0;
        end else begin
            if (load_in) begin
                out_imm <= in_imm;
                out_tag <= bus.IN_TAG;
                out_ill <= in_ill;
            end else if (load_from_skid) begin
                out_imm <= skid_imm;
                out_tag <= skid_tag;
                out_ill <= skid_ill;
            end
            if (load_skid) begin
                skid_imm <= in_imm;
                skid_tag <= bus.IN_TAG;
                skid_ill <= in_ill;
            end
        end
    end

    assign bus.IN_READY    = in_ready;
    assign bus.OUT_VALID   = out_valid;
    assign bus.OUT_IMM     = out_imm;
    assign bus.OUT_TAG     = out_tag;
    assign bus.OUT_ILLEGAL = out_ill;
endmodule
